// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t        : controller FSM states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH  : default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
// Purely combinational 1-bit full adder used as the datapath of the
// bit-serial adder.
// Ports:
//   a, b  : input  operand bits
//   c     : input  carry-in
//   s     : output sum bit      (a ^ b ^ c)
//   co    : output carry-out    (ab | bc | ac)
// -----------------------------------------------------------------------------
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (b & c) | (a & c);

endmodule : serial_fa_cell

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: captures two WIDTH-bit operands plus a carry-in on start,
// adds them one bit per clock (LSB first) through a single full-adder cell and
// presents a registered sum/carry-out with a one-cycle done pulse.
//
// Optional feature (macro SERIAL_ADD_OVF_EN): adds the ovf output, the signed
// overflow flag of the completed addition.
//
// Parameters:
//   WIDTH : operand/result width in bits (2..32)
// Ports:
//   clk   : input  rising-edge clock
//   rst   : input  synchronous active-high reset
//   start : input  request a new addition (ignored while busy)
//   a, b  : input  operands, sampled only in the capture cycle
//   cin   : input  carry-in, sampled only in the capture cycle
//   busy  : output high while the FSM is in RUN
//   done  : output one-cycle pulse while the FSM is in DONE
//   sum   : output registered result
//   cout  : output registered carry-out
//   ovf   : output registered signed overflow (SERIAL_ADD_OVF_EN only)
//
// Timing: start sampled at edge 0 enters RUN. Edges 1..WIDTH each consume one
// operand bit; edge WIDTH+1 transfers the partial result to sum/cout and
// enters DONE, so done is high in the cycle following edge WIDTH+1.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] part_reg, part_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  // Set once the MSB has been consumed; the following RUN cycle publishes
  // the result instead of consuming another bit.
  logic             fin_reg, fin_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
`ifdef SERIAL_ADD_OVF_EN
  // Carry entering the MSB position, kept for the overflow calculation.
  logic             msb_cin_reg, msb_cin_next;
  logic             ovf_reg, ovf_next;
`endif

  logic fa_s, fa_co;

  serial_fa_cell u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .c  (carry_reg),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      part_reg    <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      fin_reg     <= 1'b0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin_reg <= 1'b0;
      ovf_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      a_sh_reg    <= a_sh_next;
      b_sh_reg    <= b_sh_next;
      part_reg    <= part_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      fin_reg     <= fin_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin_reg <= msb_cin_next;
      ovf_reg     <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_sh_next    = a_sh_reg;
    b_sh_next    = b_sh_reg;
    part_next    = part_reg;
    carry_next   = carry_reg;
    cnt_next     = cnt_reg;
    fin_next     = fin_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    msb_cin_next = msb_cin_reg;
    ovf_next     = ovf_reg;
`endif

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          a_sh_next  = a;
          b_sh_next  = b;
          carry_next = cin;
          part_next  = '0;
          cnt_next   = '0;
          fin_next   = 1'b0;
          state_next = RUN;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end

      RUN: begin
        if (fin_reg) begin
          sum_next   = part_reg;
          cout_next  = carry_reg;
`ifdef SERIAL_ADD_OVF_EN
          ovf_next   = msb_cin_reg ^ carry_reg;
`endif
          state_next = DONE;
        end else begin
          // Operands shift right so bit 0 always feeds the adder; sum bits
          // enter at the top so the LSB ends up at bit 0 after WIDTH shifts.
          a_sh_next  = a_sh_reg >> 1;
          b_sh_next  = b_sh_reg >> 1;
          part_next  = {fa_s, part_reg[WIDTH-1:1]};
          carry_next = fa_co;
          if (cnt_reg == LAST_BIT) begin
            fin_next     = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            msb_cin_next = carry_reg;
`endif
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_reg;
`endif

endmodule : serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The parameter SHALL be: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 The module SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 The port list SHALL be, one port per entry:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new addition
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when the result is valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out
- ovf  output  1  signed overflow; present only under SERIAL_ADD_OVF_EN

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 In IDLE or DONE, start=1 SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter and enter RUN.
REQ-006 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-007 In DONE with start=0, the FSM SHALL return to IDLE.
REQ-008 RUN SHALL process one bit per cycle, LSB first, through a single 1-bit full adder: sum_bit = a^b^c and carry = ab|bc|ac.
REQ-009 Each RUN cycle SHALL update the carry register and shift the sum bit into the partial-result register.
REQ-010 The bit counter SHALL count 0..WIDTH-1 and be $clog2(WIDTH) bits wide.
REQ-011 When the counter reaches WIDTH-1, the next edge SHALL load sum and cout from the partial result and carry, and enter DONE.
REQ-012 If start is sampled at edge 0, done SHALL be high during the cycle after edge WIDTH+1, i.e. latency is WIDTH+1 cycles.
REQ-013 done SHALL be high only in DONE, and for exactly one cycle per completed addition.
REQ-014 busy SHALL equal (state==RUN).
REQ-015 start while busy=1 SHALL be ignored, with no effect on operands or sequencing.
REQ-016 sum and cout SHALL hold the previous result during RUN, change only on entry to DONE, and hold until the next completion.
REQ-017 start asserted in the DONE cycle SHALL be accepted, allowing back-to-back operations with one DONE cycle between runs.
REQ-018 a, b and cin SHALL be don't-care outside the capture cycle.

Reset
REQ-019 When rst=1, state SHALL become IDLE and busy, done, sum, cout, ovf, the counter and all internal registers SHALL become 0.
REQ-020 rst SHALL take priority over start.
REQ-021 A reset during RUN SHALL abort the operation: no done pulse, and sum/cout cleared to 0.

Configuration
REQ-022 With SERIAL_ADD_OVF_EN defined, the ovf port SHALL exist and be updated with sum/cout as (carry into MSB) XOR (carry out of MSB).
REQ-023 ovf SHALL hold its value until the next completion and reset to 0.
REQ-024 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-026 The 1-bit full adder SHALL be a separate combinational sub-module named serial_fa_cell (inputs a, b, c; outputs s, co), instantiated exactly once.

Verification
REQ-027 The bench SHALL cover: WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge 0 -> done at edge 9, sum=0x96, cout=0, ovf=1.
REQ-028 The bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; and a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
REQ-029 The bench SHALL cover: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-030 The bench SHALL cover: start with a=0x10, then start with a=0xEE at RUN cycle 3 -> result uses 0x10 only, exactly one done pulse.
REQ-031 The bench SHALL cover: rst at RUN cycle 4 -> IDLE next cycle, busy=0, sum=0, no done pulse; a following start completes normally.
REQ-032 The bench SHALL cover: start held high continuously -> done pulses every WIDTH+2 cycles, each result correct.
